// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and counter widths for the tristate bus arbiter and related arbiters.
package tsbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // Wide enough for HOLD_MAX up to 255 and TURNAROUND up to 15
    localparam int HOLD_W = 8;
    localparam int TURN_W = 4;

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/ownership bundle between the arbiter and the bufif0 driver netlist.
interface tristate_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] oe_n;
    logic [IDW-1:0]   grant_id;
    logic             bus_idle;
    logic             preempt;

    modport master (
        input  req,
        output grant, oe_n, grant_id, bus_idle, preempt
    );

    modport slave (
        output req,
        input  grant, oe_n, grant_id, bus_idle, preempt
    );

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching circularly from last+1.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         win,
    output logic [$clog2(N_REQ)-1:0] win_id,
    output logic                     any
);
    localparam int IDW  = $clog2(N_REQ);
    localparam int SUMW = IDW + 1;

    logic [SUMW-1:0] sum_s;
    logic [IDW-1:0]  idx_s;
    logic            hit_s;

    // Walk candidates last+1 .. last+N_REQ (mod N_REQ); the first hit wins
    always_comb begin
        win    = '0;
        win_id = '0;
        any    = 1'b0;
        sum_s  = '0;
        idx_s  = '0;
        hit_s  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum_s       = SUMW'(last) + SUMW'(i);
            sum_s       = (sum_s >= SUMW'(N_REQ)) ? (sum_s - SUMW'(N_REQ)) : sum_s;
            idx_s       = sum_s[IDW-1:0];
            hit_s       = req[idx_s] & ~any;
            win[idx_s]  = win[idx_s] | hit_s;
            win_id      = hit_s ? idx_s : win_id;
            any         = any | hit_s;
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencing for a shared pulled-up tristate wire: one bufif0 enable
// at a time, an all-off turnaround gap between owners, and a bounded tenure under contention.
module tristate_bus_arbiter
    import tsbus_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   srst,
    tristate_bus_arbiter_if.master bus
);
    localparam int                IDW       = $clog2(N_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
    localparam logic [IDW-1:0]    LAST_RST  = IDW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("tristate_bus_arbiter: N_REQ must be 2..16");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("tristate_bus_arbiter: HOLD_MAX must be 1..255");
    end
    if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
        $error("tristate_bus_arbiter: TURNAROUND must be 1..15");
    end

    state_e            state_r, state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_nxt_s;
    logic [TURN_W-1:0] turn_cnt_r, turn_nxt_s;
    logic [IDW-1:0]    last_r, last_nxt_s;
    logic [IDW-1:0]    grant_id_r, id_nxt_s;
    logic [N_REQ-1:0]  grant_r, grant_nxt_s, oe_n_r;
    logic              bus_idle_r, preempt_r, preempt_nxt_s;
    logic [N_REQ-1:0]  win_s;
    logic [IDW-1:0]    win_id_s;
    logic              any_s, owner_req_s, others_s, hold_done_s, take_s;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .last   (last_r),
        .win    (win_s),
        .win_id (win_id_s),
        .any    (any_s)
    );

    // Next-state, counter and next-output logic; take_s marks a new tenure starting
    always_comb begin
        state_nxt_s   = state_r;
        hold_nxt_s    = hold_cnt_r;
        turn_nxt_s    = turn_cnt_r;
        last_nxt_s    = last_r;
        id_nxt_s      = grant_id_r;
        grant_nxt_s   = grant_r;
        preempt_nxt_s = 1'b0;
        take_s        = 1'b0;
        owner_req_s   = |(bus.req & grant_r);
        others_s      = |(bus.req & ~grant_r);
        hold_done_s   = (hold_cnt_r >= HOLD_LAST);

        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    take_s = 1'b1;
                end else begin
                    grant_nxt_s = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s || (hold_done_s && others_s)) begin
                    state_nxt_s   = ST_TURN;
                    grant_nxt_s   = '0;
                    turn_nxt_s    = '0;
                    preempt_nxt_s = owner_req_s;
                end else if (hold_done_s) begin
                    hold_nxt_s = hold_cnt_r;
                end else begin
                    hold_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                if (turn_cnt_r >= TURN_LAST) begin
                    if (any_s) begin
                        take_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    turn_nxt_s = turn_cnt_r + TURN_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = '0;
            end
        endcase

        // A new tenure restarts the hold count and moves the round-robin pointer
        state_nxt_s = take_s ? ST_GRANT : state_nxt_s;
        grant_nxt_s = take_s ? win_s    : grant_nxt_s;
        last_nxt_s  = take_s ? win_id_s : last_nxt_s;
        id_nxt_s    = take_s ? win_id_s : id_nxt_s;
        hold_nxt_s  = take_s ? '0       : hold_nxt_s;
    end

    // State and output registers; async reset drops every driver enable without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
            last_r     <= LAST_RST;
            grant_id_r <= '0;
            grant_r    <= '0;
            oe_n_r     <= '1;
            bus_idle_r <= 1'b1;
            preempt_r  <= 1'b0;
        end else if (srst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            turn_cnt_r <= '0;
            last_r     <= LAST_RST;
            grant_id_r <= '0;
            grant_r    <= '0;
            oe_n_r     <= '1;
            bus_idle_r <= 1'b1;
            preempt_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            turn_cnt_r <= turn_nxt_s;
            last_r     <= last_nxt_s;
            grant_id_r <= id_nxt_s;
            grant_r    <= grant_nxt_s;
            oe_n_r     <= ~grant_nxt_s;
            bus_idle_r <= ~(|grant_nxt_s);
            preempt_r  <= preempt_nxt_s;
        end
    end

    assign bus.grant    = grant_r;
    assign bus.oe_n     = oe_n_r;
    assign bus.grant_id = grant_id_r;
    assign bus.bus_idle = bus_idle_r;
    assign bus.preempt  = preempt_r;

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that shares one pulled-up tristate wire among `N_REQ` active-low-enabled buffer drivers. It sequences the drivers' output enables so that at most one driver is on at any time. It inserts a programmable all-off turnaround gap between owners, and it enforces a maximum tenure when other requesters are waiting. It sits beside the gate-level bus netlist and drives the `bufif0` control pins directly.

## Interface
- `N_REQ`, default 4: number of requesters/drivers; legal range 2..16.
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while another request is pending; legal range 1..255.
- `TURNAROUND`, default 1: all-drivers-off cycles between two tenures; legal range 1..15. A value of 0 is illegal and is rejected by an elaboration-time check.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request per requester; held high for as long as bus ownership is wanted.
- `grant`  out  N_REQ  one-hot (or zero) current owner; registered.
- `oe_n`  out  N_REQ  active-low enable per bufif0 driver; registered; equals `~grant` bit-for-bit.
- `grant_id`  out  $clog2(N_REQ)  index of the current owner; holds the last owner while not granting.
- `bus_idle`  out  1  high when no driver is enabled, i.e. the pullup owns the wire.
- `preempt`  out  1  one-cycle pulse in the cycle a grant is removed because of `HOLD_MAX`.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: one owner.
  - TURN: gap; all drivers off.
- IDLE → GRANT when `req` is nonzero. The winner is the first set bit, searching circularly from `last+1`, where `last` is the previously granted index.
- GRANT → TURN when either:
  - `req[owner]` deasserts, or
  - `hold_cnt` reaches `HOLD_MAX` while any other `req` bit is set. In this case `preempt` pulses.
- GRANT stays in GRANT when the owner alone is requesting at `HOLD_MAX`. `hold_cnt` saturates and no preemption occurs.
- TURN lasts exactly `TURNAROUND` cycles, counted by `turn_cnt`. It then goes to GRANT if any `req` bit is set, otherwise to IDLE. The preempted owner is eligible again, but only after all others in round-robin order.
- `hold_cnt` clears on entry to GRANT and increments every GRANT cycle.
- `last` updates on every GRANT entry.
- Requests that arrive during TURN are not lost; they are evaluated at TURN exit.
- `bus_idle = (grant == 0)`.

## Timing
- Reset (asynchronous assert; deassertion synchronised externally):
  - `grant` = 0, `oe_n` = all ones, `grant_id` = 0, `bus_idle` = 1, `preempt` = 0.
  - State = IDLE, `last` = N_REQ-1, so the first win goes to index 0.
  - Reset asserted mid-tenure turns every driver off immediately, with no wait for a clock edge.
- Request-to-grant latency from IDLE: 1 cycle. A `req` that is high at edge k gives `grant` high after edge k.
- Release latency: owner `req` low at edge k → `grant` zero after edge k. This is followed by `TURNAROUND` zero cycles; the next grant at the earliest appears after edge k+TURNAROUND.
- Overlap guarantee: no two `oe_n` bits are low in the same cycle, and no cycle moves directly from owner A to owner B without a gap.
- Maximum tenure with contention: exactly `HOLD_MAX` cycles of `grant` high.
- Simultaneous requests: round-robin order only; no fixed priority.
- An owner that drops and re-raises `req` within its own TURN window competes normally at TURN exit.

## Structure
- Shared package `tsbus_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_GRANT`, `ST_TURN`).
  - Localparam widths for the hold and turn counters.
- Sub-module `rr_pick`: combinational circular first-one finder.
  - Inputs: `req`, `last`.
  - Outputs: one-hot winner, winner index, `any`.
  - Reusable by other arbiters in the design.
- Everything else (FSM, counters, output registers) lives in `tristate_bus_arbiter`.

## Test plan
- Reset: assert `rst_n`=0 mid-GRANT for owner 2 → `oe_n`=4'b1111 and `bus_idle`=1 with no clock edge; after release, the first `req`=4'b1111 grants index 0.
- Round robin: `req`=4'b1111 held with `HOLD_MAX`=8 and `TURNAROUND`=1 → grants 0,1,2,3,0, each 8 cycles long, separated by one idle cycle, with a `preempt` pulse at each handoff.
- Voluntary release: single `req[1]` for 3 cycles → `grant`=4'b0010 for 3 cycles, then 0, then IDLE; `preempt` never pulses.
- No contention: `req[3]` alone for 20 cycles → continuous grant, `hold_cnt` saturated, no preemption.
- Turnaround: `TURNAROUND`=3; owner 0 drops while `req[2]` is high → exactly 3 cycles with `grant`=0, then `grant`=4'b0100.
- Safety assertion, run throughout random `req` traffic: `$onehot0(~oe_n)` holds every cycle, and there is never an adjacent-cycle owner change without a zero cycle between.
